// File: rtl/idma_rd_pkg.sv
// Shared constants and state type for the iDMA 128-bit read burst scheduler.
package idma_rd_pkg;

  localparam int unsigned BEAT_BYTES      = 16;
  localparam int unsigned MAX_BURST_BEATS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/idma_rd_outstd_cnt.sv
// Outstanding AXI read burst counter; flags when another (possibly split) burst would overflow the window.
module idma_rd_outstd_cnt #(
  parameter int unsigned MAX_OUTSTD = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       inc1,
  input  logic       inc2,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       arvld_disable
);

  logic [4:0] cnt_next;

  // Increment and decrement net out in one cycle; a return with nothing outstanding is dropped.
  always_comb begin
    cnt_next = {1'b0, cnt};
    if (inc2) begin
      cnt_next = cnt_next + 5'd2;
    end else if (inc1) begin
      cnt_next = cnt_next + 5'd1;
    end
    if (dec && (cnt != 4'd0)) begin
      cnt_next = cnt_next - 5'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_next[3:0];
    end
  end

  // Room is reserved for two bursts since the next one may be split at a 4K boundary.
  assign arvld_disable = (({1'b0, cnt} + 5'd2) > 5'(MAX_OUTSTD));

endmodule

// File: rtl/idma_rd_burst_sched.sv
// Read-DMA burst scheduler: slices one command into <=16-beat bursts and tracks outstanding reads.
// Optional macro IDMA_RD_BURST_ALIGN_EN: first burst stops at the next 256 B boundary.
module idma_rd_burst_sched
  import idma_rd_pkg::*;
#(
  parameter int unsigned MAX_OUTSTD = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_beats,
  output logic             dma_trans_burst_avalid,
  output logic [31:0]      dma_trans_burst_addr,
  output logic [3:0]       dma_trans_burst_len,
  input  logic             dma_xaddr_burst_ok,
  input  logic             cross_4k_flag,
  input  logic             axi_burst_xdata_ok,
  output logic             x_burst_arvld_disable,
  output logic             busy,
  output logic             done
);

  sched_state_e     state;
  sched_state_e     state_next;
  logic [31:0]      burst_addr;
  logic [LEN_W-1:0] remaining;
  logic [4:0]       burst_beats;
  logic [3:0]       outstd_cnt;
  logic             issuing;
  logic             burst_ok;
  logic             last_burst;
  logic             accept;

  assign issuing    = (state == ISSUE);
  assign burst_ok   = issuing & dma_xaddr_burst_ok;
  assign accept     = (state == IDLE) & cmd_valid;
  assign last_burst = (remaining == LEN_W'(burst_beats));

`ifdef IDMA_RD_BURST_ALIGN_EN
  logic [4:0] boundary_beats;

  // After the first burst the address is 256 B aligned, so this cap only bites once.
  assign boundary_beats = 5'(MAX_BURST_BEATS) - {1'b0, burst_addr[7:4]};

  always_comb begin
    burst_beats = 5'(MAX_BURST_BEATS);
    if (remaining < LEN_W'(MAX_BURST_BEATS)) begin
      burst_beats = remaining[4:0];
    end
    if (boundary_beats < burst_beats) begin
      burst_beats = boundary_beats;
    end
  end
`else
  always_comb begin
    burst_beats = 5'(MAX_BURST_BEATS);
    if (remaining < LEN_W'(MAX_BURST_BEATS)) begin
      burst_beats = remaining[4:0];
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cmd_ready is masked by reset so every output reads zero while aresetn is low.
  always_comb begin
    state_next             = state;
    cmd_ready              = 1'b0;
    busy                   = 1'b1;
    dma_trans_burst_avalid = 1'b0;
    done                   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = aresetn;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_next = (cmd_beats == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        dma_trans_burst_avalid = 1'b1;
        if (dma_xaddr_burst_ok && last_burst) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstd_cnt == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      burst_addr <= 32'd0;
      remaining  <= '0;
    end else if (accept) begin
      burst_addr <= cmd_addr & 32'hFFFF_FFF0;
      remaining  <= cmd_beats;
    end else if (burst_ok) begin
      burst_addr <= burst_addr + {23'd0, burst_beats, 4'd0};
      remaining  <= remaining - LEN_W'(burst_beats);
    end
  end

  assign dma_trans_burst_addr = issuing ? burst_addr : 32'd0;
  assign dma_trans_burst_len  = issuing ? 4'(burst_beats - 5'd1) : 4'd0;

  idma_rd_outstd_cnt #(
    .MAX_OUTSTD(MAX_OUTSTD)
  ) u_outstd_cnt (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .inc1         (burst_ok & ~cross_4k_flag),
    .inc2         (burst_ok & cross_4k_flag),
    .dec          (axi_burst_xdata_ok),
    .cnt          (outstd_cnt),
    .arvld_disable(x_burst_arvld_disable)
  );

endmodule
